// File: rtl/vga_fb_arbiter_pkg.sv
// Shared constants, clear-engine state encoding and the RGB332 colour expansion
// used by the framebuffer arbiter.
package rr_vga_pkg;

  localparam int unsigned FB_W     = 160;
  localparam int unsigned FB_H     = 120;
  localparam int unsigned FB_DEPTH = FB_W * FB_H;
  localparam int unsigned AW       = 15;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  // Bit replication keeps full-scale values mapping to 8'hFF.
  function automatic logic [23:0] rgb332_expand(input logic [7:0] d);
    return {d[7:5], d[7:5], d[7:6],
            d[4:2], d[4:2], d[4:3],
            d[1:0], d[1:0], d[1:0], d[1:0]};
  endfunction

endpackage

// File: rtl/vga_fb_arbiter_clear.sv
// Screen-clear engine: walks every framebuffer address once, writing the colour
// latched at start, advancing only in cycles the arbiter grants it.
module fb_clear_engine
  import rr_vga_pkg::*;
#(
  parameter int unsigned DEPTH = rr_vga_pkg::FB_DEPTH,
  parameter int unsigned AW_P  = rr_vga_pkg::AW
) (
  input  logic            CLOCK_50,
  input  logic            reset,
  input  logic            i_start,
  input  logic [7:0]      i_color,
  input  logic            i_grant,
  output logic            o_busy,
  output logic            o_we,
  output logic [AW_P-1:0] o_addr,
  output logic [7:0]      o_data
);

  localparam logic [AW_P-1:0] LAST = AW_P'(DEPTH - 1);

  logic [0:0]      r_state;
  logic [AW_P-1:0] r_cnt;
  logic [7:0]      r_color;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_color <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_color <= i_color;
          end
        end
        ST_CLEAR: begin
          if (i_grant) begin
            if (r_cnt == LAST) begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + AW_P'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy = (r_state == ST_CLEAR);
  assign o_we   = o_busy & i_grant;
  assign o_addr = r_cnt;
  assign o_data = r_color;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: scanout reads on vga_clk-high active cycles,
// clear engine then request/ack writer in all other cycles, RGB332 -> 888 output.
module vga_fb_arbiter
  import rr_vga_pkg::*;
#(
  parameter int unsigned FB_W        = rr_vga_pkg::FB_W,
  parameter int unsigned FB_H        = rr_vga_pkg::FB_H,
  parameter int unsigned SCALE_SHIFT = 2,
  parameter int unsigned AW          = rr_vga_pkg::AW
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          vga_clk,
  input  logic          printing,
  input  logic [9:0]    i,
  input  logic [9:0]    j,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  output logic          wr_ack,
  input  logic          clear_req,
  input  logic [7:0]    clear_color,
  output logic          clear_busy,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [7:0]    ram_wdata,
  input  logic [7:0]    ram_rdata,
  output logic [7:0]    pix_r,
  output logic [7:0]    pix_g,
  output logic [7:0]    pix_b
);

  localparam int unsigned DEPTH = FB_W * FB_H;

  logic          w_scan;
  logic [9:0]    w_row;
  logic [9:0]    w_col;
  logic [AW-1:0] w_scan_addr;
  logic          w_wr_in_range;
  logic          w_grant;
  logic          w_clr_busy;
  logic          w_clr_we;
  logic [AW-1:0] w_clr_addr;
  logic [7:0]    w_clr_data;

  logic          r_rd_pending;
  logic          r_blank_pend;
  logic [7:0]    r_pix_r;
  logic [7:0]    r_pix_g;
  logic [7:0]    r_pix_b;

  assign w_scan        = vga_clk & printing;
  assign w_row         = i >> SCALE_SHIFT;
  assign w_col         = j >> SCALE_SHIFT;
  assign w_scan_addr   = AW'(w_row) * AW'(FB_W) + AW'(w_col);
  assign w_wr_in_range = (32'(wr_addr) < DEPTH);

  fb_clear_engine #(
    .DEPTH (DEPTH),
    .AW_P  (AW)
  ) u_clear (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .i_start  (clear_req),
    .i_color  (clear_color),
    .i_grant  (w_grant),
    .o_busy   (w_clr_busy),
    .o_we     (w_clr_we),
    .o_addr   (w_clr_addr),
    .o_data   (w_clr_data)
  );

  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    wr_ack    = 1'b0;
    w_grant   = 1'b0;
    if (!reset) begin
      if (w_scan) begin
        ram_addr = w_scan_addr;
      end else if (w_clr_busy) begin
        w_grant   = 1'b1;
        ram_addr  = w_clr_addr;
        ram_we    = w_clr_we;
        ram_wdata = w_clr_data;
      end else if (wr_req) begin
        // Out-of-range writes are still acknowledged so the writer never stalls.
        wr_ack = 1'b1;
        if (w_wr_in_range) begin
          ram_we    = 1'b1;
          ram_addr  = wr_addr;
          ram_wdata = wr_data;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_rd_pending <= 1'b0;
      r_blank_pend <= 1'b0;
      r_pix_r      <= '0;
      r_pix_g      <= '0;
      r_pix_b      <= '0;
    end else begin
      r_rd_pending <= w_scan;
      r_blank_pend <= vga_clk & ~printing;
      if (r_rd_pending) begin
        {r_pix_r, r_pix_g, r_pix_b} <= rgb332_expand(ram_rdata);
      end else if (r_blank_pend) begin
        r_pix_r <= '0;
        r_pix_g <= '0;
        r_pix_b <= '0;
      end
    end
  end

  assign clear_busy = w_clr_busy;
  assign pix_r      = r_pix_r;
  assign pix_g      = r_pix_g;
  assign pix_b      = r_pix_b;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Randomised and directed bench for vga_fb_arbiter with a behavioural RAM and
// a slot-level reference model of the arbiter.
module tb_vga_fb_arbiter;

  localparam int DEPTH = 19200;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        vga_clk = 1'b0;
  logic        printing = 1'b0;
  logic [9:0]  i = '0;
  logic [9:0]  j = '0;
  logic        wr_req = 1'b0;
  logic [14:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        wr_ack;
  logic        clear_req = 1'b0;
  logic [7:0]  clear_color = '0;
  logic        clear_busy;
  logic [14:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = '0;
  logic [7:0]  pix_r, pix_g, pix_b;

  vga_fb_arbiter #(
    .FB_W        (160),
    .FB_H        (120),
    .SCALE_SHIFT (2),
    .AW          (15)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .vga_clk     (vga_clk),
    .printing    (printing),
    .i           (i),
    .j           (j),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ack      (wr_ack),
    .clear_req   (clear_req),
    .clear_color (clear_color),
    .clear_busy  (clear_busy),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .pix_r       (pix_r),
    .pix_g       (pix_g),
    .pix_b       (pix_b)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  logic [7:0] mem [0:32767];

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit         m_clr   = 0;
  int         m_cnt   = 0;
  logic [7:0] m_color = '0;
  bit         m_rdp   = 0;
  bit         m_blank = 0;
  logic [7:0] m_rd_byte = '0;
  logic [23:0] m_pix  = '0;

  int  cnt_clr_wr = 0;
  bit  last_ack   = 0;
  bit  last_busy  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] exp_pix(input logic [7:0] d);
    int r, g, b;
    r = d >> 5;
    g = (d >> 2) & 7;
    b = d & 3;
    return {8'(36 * r + (r >> 1)), 8'(36 * g + (g >> 1)), 8'(85 * b)};
  endfunction

  // One CLOCK_50 cycle; called just after a falling edge with inputs driven.
  task automatic step();
    bit s_scan, s_reset, s_vga, s_print, s_clrreq;
    logic [7:0] s_color, s_rd_byte;
    bit ewe, eack, chk_a;
    int eaddr;
    logic [7:0] ewd;
    logic [14:0] a_addr;
    logic a_we, a_ack;
    logic [7:0] a_wd;
    #2;
    s_reset  = reset;
    s_vga    = vga_clk;
    s_print  = printing;
    s_clrreq = clear_req;
    s_color  = clear_color;
    s_scan   = vga_clk && printing;
    ewe = 0; eack = 0; chk_a = 0; eaddr = 0; ewd = '0; s_rd_byte = '0;
    if (!s_reset) begin
      chk_a = 1;
      if (s_scan) begin
        eaddr = (int'(i) / 4) * 160 + int'(j) / 4;
        s_rd_byte = mem[eaddr];
      end else if (m_clr) begin
        ewe = 1; eaddr = m_cnt; ewd = m_color;
      end else if (wr_req) begin
        eack = 1;
        if (int'(wr_addr) < DEPTH) begin
          ewe = 1; eaddr = int'(wr_addr); ewd = wr_data;
        end else chk_a = 0;
      end
    end
    chk("ram_we", ram_we, ewe);
    chk("wr_ack", wr_ack, eack);
    if (chk_a) chk("ram_addr", ram_addr, eaddr);
    if (ewe) chk("ram_wdata", ram_wdata, ewd);
    a_addr = ram_addr; a_we = ram_we; a_wd = ram_wdata; a_ack = wr_ack;
    last_ack  = a_ack;
    last_busy = clear_busy;
    if (a_we && !a_ack) cnt_clr_wr++;
    @(posedge CLOCK_50);
    #1;
    ram_rdata = mem[a_addr];
    if (a_we) mem[a_addr] = a_wd;
    if (s_reset) begin
      m_clr = 0; m_cnt = 0; m_color = '0; m_rdp = 0; m_blank = 0; m_pix = '0;
    end else begin
      if (m_rdp) m_pix = exp_pix(m_rd_byte);
      else if (m_blank) m_pix = '0;
      m_rdp   = s_scan;
      m_blank = s_vga && !s_print;
      if (s_scan) m_rd_byte = s_rd_byte;
      if (m_clr) begin
        if (!s_scan) begin
          m_cnt++;
          if (m_cnt == DEPTH) begin m_clr = 0; m_cnt = 0; end
        end
      end else if (s_clrreq) begin
        m_clr = 1; m_cnt = 0; m_color = s_color;
      end
    end
    chk("pix_r", pix_r, m_pix[23:16]);
    chk("pix_g", pix_g, m_pix[15:8]);
    chk("pix_b", pix_b, m_pix[7:0]);
    chk("clear_busy", clear_busy, m_clr);
    @(negedge CLOCK_50);
  endtask

  initial begin
    int base, saved;
    bit got;
    for (int k = 0; k < 32768; k++) mem[k] = 8'($urandom);
    mem[162] = 8'h92;
    mem[0]   = 8'hE0;

    // reset with a pending write request
    reset = 1; wr_req = 1; wr_addr = 15'd10; wr_data = 8'h11;
    repeat (3) step();
    chk("rst_pix_r", pix_r, 0);
    chk("rst_pix_b", pix_b, 0);
    chk("rst_busy", clear_busy, 0);
    reset = 0; wr_req = 0;

    // scanout read i=5,j=9 -> address 162, data 0x92
    vga_clk = 1; printing = 1; i = 10'd5; j = 10'd9;
    #1; chk("scan_addr_162", ram_addr, 162); chk("scan_we0", ram_we, 0);
    step();
    vga_clk = 0; step();
    chk("exp92_r", pix_r, 8'h92); chk("exp92_g", pix_g, 8'h92); chk("exp92_b", pix_b, 8'hAA);
    vga_clk = 1; i = 10'd0; j = 10'd0; step();
    vga_clk = 0; step();
    chk("expE0_r", pix_r, 8'hFF); chk("expE0_g", pix_g, 8'h00); chk("expE0_b", pix_b, 8'h00);
    vga_clk = 1; printing = 0; step();
    vga_clk = 0; step();
    chk("blank_pix_zero", pix_r, 8'h00);

    // writer during active video: only served in the vga_clk low cycle
    printing = 1; vga_clk = 1; wr_req = 1; wr_addr = 15'd100; wr_data = 8'h1C;
    #1; chk("wr_no_ack_scan", wr_ack, 0);
    step();
    vga_clk = 0;
    #1; chk("wr_ack_low", wr_ack, 1); chk("wr_addr100", ram_addr, 100); chk("wr_data1C", ram_wdata, 8'h1C);
    step(); wr_req = 0;
    printing = 0; vga_clk = 1; wr_req = 1; wr_addr = 15'd101; wr_data = 8'h33;
    #1; chk("wr_ack_blank", wr_ack, 1);
    step();
    wr_addr = 15'd19200;
    #1; chk("oor_ack", wr_ack, 1); chk("oor_we0", ram_we, 0);
    step(); wr_req = 0;

    // full clear during blanking, writer held until clear completes
    clear_req = 1; clear_color = 8'h03; vga_clk = 0; step();
    clear_req = 0; clear_color = 8'hFF;
    wr_req = 1; wr_addr = 15'd50; wr_data = 8'h55;
    base = cnt_clr_wr; got = 0;
    for (int k = 0; k < 20000 && !got; k++) begin
      vga_clk = ~vga_clk; step();
      if (last_ack) got = 1;
    end
    wr_req = 0;
    chk("clear_ack_seen", got, 1);
    chk("clear_write_count", cnt_clr_wr - base, DEPTH);
    chk("busy_low_at_ack", last_busy, 0);
    chk("clear_mem_first", mem[0], 8'h03);
    chk("clear_mem_last", mem[19199], 8'h03);

    // clear during active video, aborted by reset after 5000 writes
    printing = 1; clear_req = 1; clear_color = 8'h5A; step();
    clear_req = 0;
    base = cnt_clr_wr;
    for (int k = 0; k < 15000 && (cnt_clr_wr - base) < 5000; k++) begin
      vga_clk = ~vga_clk; i = 10'($urandom % 480); j = 10'($urandom % 640);
      step();
    end
    chk("mid_clear_count", cnt_clr_wr - base, 5000);
    reset = 1; step();
    chk("abort_busy0", clear_busy, 0);
    reset = 0; printing = 0; saved = cnt_clr_wr;
    repeat (10) begin vga_clk = ~vga_clk; step(); end
    chk("no_writes_after_abort", cnt_clr_wr - saved, 0);
    chk("partial_4999", mem[4999], 8'h5A);
    chk("partial_5000", mem[5000], 8'h03);
    clear_req = 1; clear_color = 8'hC3; step();
    clear_req = 0;
    repeat (3) step();
    chk("restart_0", mem[0], 8'hC3);
    chk("restart_2", mem[2], 8'hC3);
    chk("restart_3", mem[3], 8'h5A);
    reset = 1; step(); reset = 0;

    // randomised traffic
    for (int k = 0; k < 4000; k++) begin
      if ($urandom % 16 == 0) vga_clk = 1'($urandom);
      else vga_clk = ~vga_clk;
      if (k % 8 == 0) printing = ($urandom % 4) != 0;
      i = 10'($urandom % 480); j = 10'($urandom % 640);
      if (!wr_req && ($urandom % 2 == 1)) begin
        wr_req = 1;
        wr_addr = ($urandom % 8 == 0) ? 15'(19200 + $urandom % 13000) : 15'($urandom % 19200);
        wr_data = 8'($urandom);
      end
      step();
      if (last_ack) wr_req = 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port synchronous framebuffer RAM between VGA scanout reads and game-logic writes.
- The framebuffer is 160x120, RGB332, 8 bits per pixel. Each framebuffer pixel is shown as a 4x4 block on the 640x480 screen.
- The block has three jobs:
  - Issue scanout reads in lock-step with the VGA timing generator's pixel clock.
  - Expand each RGB332 pixel to 8/8/8 for the timing generator's colour inputs.
  - Grant the spare RAM slots to a request/ack writer and to a built-in screen-clear engine.

Parameters:
- FB_W, 160, framebuffer width in pixels.
- FB_H, 120, framebuffer height in pixels.
- SCALE_SHIFT, 2, log2 of the screen-to-framebuffer scale.
- AW, 15, RAM address width; must satisfy 2^AW >= FB_W*FB_H.

Ports:
- CLOCK_50  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- vga_clk  in  1  25 MHz pixel clock from the timing generator, sampled as data, not used as a clock.
- printing  in  1  timing generator is in the active window.
- i  in  10  active line 0..479.
- j  in  10  active column 0..639.
- wr_req  in  1  writer request; held with addr/data until wr_ack.
- wr_addr  in  AW  writer framebuffer address.
- wr_data  in  8  writer RGB332 pixel.
- wr_ack  out  1  one-cycle pulse; the write was performed or dropped this cycle.
- clear_req  in  1  pulse; fill the framebuffer with clear_color.
- clear_color  in  8  RGB332 fill value, latched on accept.
- clear_busy  out  1  clear in progress.
- ram_addr  out  AW  RAM address.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  8  RAM write data.
- ram_rdata  in  8  RAM read data, valid one cycle after its address.
- pix_r  out  8  expanded red to the timing generator.
- pix_g  out  8  expanded green to the timing generator.
- pix_b  out  8  expanded blue to the timing generator.

Behaviour:
- Slot classification, per CLOCK_50 cycle:
  - Scanout slot: vga_clk==1 and printing==1.
  - Every other cycle is a writer slot. During blanking, every cycle is a writer slot.
- Scanout slot:
  - ram_we=0.
  - ram_addr = (i>>SCALE_SHIFT)*FB_W + (j>>SCALE_SHIFT). Computed as (row<<7)+(row<<5)+col for the default parameters; truncate to AW bits.
  - A registered rd_pending flag is set for the next cycle.
- Read data capture:
  - Cycle after a scanout slot: pix_* <= expand(ram_rdata). Latency from address to pix_* is 2 CLOCK_50 cycles, so pix_* is stable before the next vga_clk rise.
  - Cycle after a vga_clk==1 cycle with printing==0: pix_* <= 0.
  - Otherwise pix_* holds.
- RGB332 expansion:
  - pix_r = {d[7:5],d[7:5],d[7:6]}.
  - pix_g = {d[4:2],d[4:2],d[4:3]}.
  - pix_b = {d[1:0],d[1:0],d[1:0],d[1:0]}.
- Writer slot priority:
  - First, the clear engine when in state CLEAR.
  - Then wr_req.
  - Otherwise idle: ram_we=0, ram_addr=0.
- Writer service (wr_req=1, granted):
  - wr_ack=1 in the same cycle.
  - If wr_addr < FB_W*FB_H: ram_we=1, ram_addr=wr_addr, ram_wdata=wr_data.
  - If wr_addr >= FB_W*FB_H: acknowledged but dropped, ram_we=0.
  - wr_ack is never asserted in a scanout slot or while in CLEAR.
- State machine:
  - IDLE -> CLEAR on clear_req: latch clear_color, clr_cnt<=0, clear_busy<=1.
  - CLEAR, each writer slot: write the latched colour to clr_cnt, then clr_cnt++.
  - CLEAR -> IDLE after the write at clr_cnt == FB_W*FB_H-1; clear_busy deasserts the next cycle.
  - clear_req while in CLEAR is ignored.
  - clear_req and wr_req together in IDLE: CLEAR wins from the next cycle; a writer slot in the accepting cycle still serves wr_req.
- Combinational and registered outputs:
  - ram_addr, ram_we, ram_wdata and wr_ack are combinational from registered state and current inputs.
  - pix_*, clear_busy, state, clr_cnt and rd_pending are registered.
- Reset:
  - Reset values: pix_*=0, clear_busy=0, state=IDLE, clr_cnt=0, rd_pending=0.
  - While reset is high: ram_we=0 and wr_ack=0.
  - Reset mid-clear aborts the clear; partially cleared contents remain.

Decomposition:
- Package rr_vga_pkg holds:
  - FB_W, FB_H, FB_DEPTH=FB_W*FB_H, AW.
  - The IDLE/CLEAR state encoding.
  - The rgb332_expand function.
- Sub-module fb_clear_engine: latched colour, clr_cnt, busy, and a grant input/write-strobe output.

Test Plan:
- Reset held 3 cycles with wr_req=1 -> wr_ack=0, ram_we=0, pix_*=0, clear_busy=0.
- printing=1, i=5, j=9, vga_clk=1 -> ram_addr=162, ram_we=0; ram_rdata=0x92 next cycle -> pix_r=0x92, pix_g=0x92, pix_b=0xAA one cycle later; 0xE0 -> pix_r=0xFF, pix_g=0x00, pix_b=0x00.
- Active video, wr_req with addr 100, data 0x1C -> wr_ack and ram_we only in a vga_clk==0 cycle, ram_addr=100, ram_wdata=0x1C; during blanking -> acked in the first cycle.
- wr_addr=19200 -> wr_ack pulses, ram_we stays 0.
- clear_req with clear_color=0x03 during vertical blanking -> 19200 consecutive writes to addresses 0..19199 with data 0x03, clear_busy low the cycle after the last write; a wr_req held throughout is acked only after that.
- Reset asserted at clr_cnt=5000 -> clear_busy=0 the next cycle, no further clear writes, a new clear_req restarts from address 0.
